// File: rtl/cpu_timing_pkg.sv
// Shared types for the machine-cycle timing generator: beat, phase and run-state encodings.
package cpu_timing_pkg;

    localparam int NUM_PHASES = 4;

    typedef enum logic [1:0] {W1 = 2'd0, W2 = 2'd1, W3 = 2'd2} beat_e;
    typedef enum logic [1:0] {T1 = 2'd0, T2 = 2'd1, T3 = 2'd2, T4 = 2'd3} phase_e;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} run_e;

endpackage

// File: rtl/key_sync_edge.sv
// Start-key synchroniser with a single-cycle rising-edge pulse.
module key_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Reset loads ones so a key already held at reset release never reads as an edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/beat_timing_gen.sv
// Machine-cycle timing generator: phase pulses t1..t4 and beats w1..w3 for the hardwired controller.
// Optional SINGLE_STEP_EN adds the dp single-beat input.
module beat_timing_gen
    import cpu_timing_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int PHASE_CYCLES = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic i_qd,
    input  logic i_short,
    input  logic i_long,
    input  logic i_stop,
`ifdef SINGLE_STEP_EN
    input  logic i_dp,
`endif
    output logic o_t1,
    output logic o_t2,
    output logic o_t3,
    output logic o_t4,
    output logic o_w1,
    output logic o_w2,
    output logic o_w3,
    output logic o_running
);

    localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);

    logic                  w_qd_rise;
    logic                  w_halt;
    run_e                  r_state, w_state_nxt;
    phase_e                r_phase, w_phase_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    beat_e                 r_beat, w_beat_nxt;
    logic [NUM_PHASES-1:0] w_t_nxt, r_t;
    logic [2:0]            w_w_nxt, r_w;
    logic                  r_running;

    key_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_sync (
        .clk     (clk),
        .clr     (clr),
        .i_async (i_qd),
        .o_rise  (w_qd_rise)
    );

`ifdef SINGLE_STEP_EN
    assign w_halt = i_stop | i_dp;
`else
    assign w_halt = i_stop;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_phase <= T1;
            r_cnt   <= '0;
            r_beat  <= W1;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // Controller requests are only consulted on the final clk of T4.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_qd_rise) begin
                    w_state_nxt = RUN;
                    w_phase_nxt = T1;
                    w_cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    case (r_phase)
                        T1:      w_phase_nxt = T2;
                        T2:      w_phase_nxt = T3;
                        T3:      w_phase_nxt = T4;
                        default: w_phase_nxt = T1;
                    endcase
                    if (r_phase == T4) begin
                        case (r_beat)
                            W1:      w_beat_nxt = i_short ? W1 : W2;
                            W2:      w_beat_nxt = i_long ? W3 : W1;
                            default: w_beat_nxt = W1;
                        endcase
                        if (w_halt) begin
                            w_state_nxt = IDLE;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_t_nxt = '0;
        if (w_state_nxt == RUN) begin
            case (w_phase_nxt)
                T1:      w_t_nxt = 4'b0001;
                T2:      w_t_nxt = 4'b0010;
                T3:      w_t_nxt = 4'b0100;
                default: w_t_nxt = 4'b1000;
            endcase
        end
        case (w_beat_nxt)
            W2:      w_w_nxt = 3'b010;
            W3:      w_w_nxt = 3'b100;
            default: w_w_nxt = 3'b001;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_t       <= '0;
            r_w       <= 3'b001;
            r_running <= 1'b0;
        end else begin
            r_t       <= w_t_nxt;
            r_w       <= w_w_nxt;
            r_running <= (w_state_nxt == RUN);
        end
    end

    assign o_t1      = r_t[0];
    assign o_t2      = r_t[1];
    assign o_t3      = r_t[2];
    assign o_t4      = r_t[3];
    assign o_w1      = r_w[0];
    assign o_w2      = r_w[1];
    assign o_w3      = r_w[2];
    assign o_running = r_running;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Bench for beat_timing_gen: PHASE_CYCLES=1 and =3 instances share stimulus, checked against a beat-position model.
module tb_beat_timing_gen;

    localparam int S    = 2;
    localparam int PC_A = 1;
    localparam int PC_B = 3;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic qd = 1'b0, sh = 1'b0, lg = 1'b0, st = 1'b0, dp = 1'b0;

    // {running, t1, t2, t3, t4, w1, w2, w3}
    wire [7:0] v_a, v_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    beat_timing_gen #(.SYNC_STAGES(S), .PHASE_CYCLES(PC_A)) dut_a (
        .clk(clk), .clr(clr), .i_qd(qd), .i_short(sh), .i_long(lg), .i_stop(st),
`ifdef SINGLE_STEP_EN
        .i_dp(dp),
`endif
        .o_t1(v_a[6]), .o_t2(v_a[5]), .o_t3(v_a[4]), .o_t4(v_a[3]),
        .o_w1(v_a[2]), .o_w2(v_a[1]), .o_w3(v_a[0]), .o_running(v_a[7])
    );

    beat_timing_gen #(.SYNC_STAGES(S), .PHASE_CYCLES(PC_B)) dut_b (
        .clk(clk), .clr(clr), .i_qd(qd), .i_short(sh), .i_long(lg), .i_stop(st),
`ifdef SINGLE_STEP_EN
        .i_dp(dp),
`endif
        .o_t1(v_b[6]), .o_t2(v_b[5]), .o_t3(v_b[4]), .o_t4(v_b[3]),
        .o_w1(v_b[2]), .o_w2(v_b[1]), .o_w3(v_b[0]), .o_running(v_b[7])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: position k within the beat (0 .. 4*PC-1), beat number, run flag.
    // The start key is seen S clocks late; an edge needs a low sample followed by a high one.
    bit m_run[2];
    int m_k[2];
    int m_beat[2];
    bit hist[$];

    function automatic int pc_of(input int i);
        return (i == 0) ? PC_A : PC_B;
    endfunction

    function automatic logic [7:0] exp_vec(input int i);
        int ph;
        ph = m_k[i] / pc_of(i);
        return {m_run[i], m_run[i] && ph == 0, m_run[i] && ph == 1, m_run[i] && ph == 2,
                m_run[i] && ph == 3, m_beat[i] == 0, m_beat[i] == 1, m_beat[i] == 2};
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            hist.delete();
            for (int j = 0; j <= S; j++) hist.push_back(1'b1);
            for (int i = 0; i < 2; i++) begin
                m_run[i]  = 1'b0;
                m_k[i]    = 0;
                m_beat[i] = 0;
            end
        end else begin
            bit rise;
            bit halt;
            hist.push_back(qd);
            rise = hist[hist.size() - 1 - S] && !hist[hist.size() - 2 - S];
            while (hist.size() > S + 2) void'(hist.pop_front());
            halt = st;
`ifdef SINGLE_STEP_EN
            halt = st | dp;
`endif
            for (int i = 0; i < 2; i++) begin
                if (m_run[i]) begin
                    if (m_k[i] == 4 * pc_of(i) - 1) begin
                        m_k[i] = 0;
                        if (m_beat[i] == 0)      m_beat[i] = sh ? 0 : 1;
                        else if (m_beat[i] == 1) m_beat[i] = lg ? 2 : 0;
                        else                     m_beat[i] = 0;
                        if (halt) m_run[i] = 1'b0;
                    end else begin
                        m_k[i] = m_k[i] + 1;
                    end
                end else if (rise) begin
                    m_run[i] = 1'b1;
                    m_k[i]   = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (clr) begin
            check_eq("cycle_pc1", {24'd0, v_a}, {24'd0, exp_vec(0)});
            check_eq("cycle_pc3", {24'd0, v_b}, {24'd0, exp_vec(1)});
        end
    end

    initial begin
        int lat, n_a, n_b, hold;
        bit found;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset_pc1", {24'd0, v_a}, 32'h04);
        check_eq("reset_pc3", {24'd0, v_b}, 32'h04);
        clr = 1'b1;

        // Start latency and free-running beat length
        repeat (5) @(negedge clk);
        qd  = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (v_a[6]) break;
        end
        check_eq("t1_latency", lat, S + 1);
        check_eq("t1_pc3_same_clk", {31'd0, v_b[6]}, 32'd1);
        n_a = 0;
        n_b = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (n_a == 0 && v_a[1]) n_a = i;
            if (n_b == 0 && v_b[1]) n_b = i;
            if (n_a != 0 && n_b != 0) break;
        end
        check_eq("beat_len_pc1", n_a, 4);
        check_eq("beat_len_pc3", n_b, 12);
        @(negedge clk);
        qd = 1'b0;

        // Stop requested in W2 T4
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (v_a[1] && v_a[3]) found = 1'b1;
        end
        check_eq("find_w2t4", {31'd0, found}, 32'd1);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        check_eq("stop_idle", {24'd0, v_a}, 32'h04);

        // Resume from idle at T1 of W1
        repeat (2) @(negedge clk);
        qd  = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (v_a[6]) break;
        end
        check_eq("resume_latency", lat, S + 1);
        check_eq("resume_vec", {24'd0, v_a}, 32'hC4);
        @(negedge clk);
        qd = 1'b0;

        // Asynchronous clear in W2 T2
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (v_a[1] && v_a[5]) found = 1'b1;
        end
        check_eq("find_w2t2", {31'd0, found}, 32'd1);
        #2 clr = 1'b0;
        #1;
        check_eq("clr_async_pc1", {24'd0, v_a}, 32'h04);
        check_eq("clr_async_pc3", {24'd0, v_b}, 32'h04);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;

        // Randomized controller requests and key activity
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            sh = ($urandom_range(0, 3) == 0);
            lg = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 11) == 0);
            dp = ($urandom_range(0, 5) == 0);
            if (hold == 0) begin
                qd   = ~qd;
                hold = $urandom_range(0, 8);
            end else begin
                hold--;
            end
            if (c == 2500) begin
                #1 clr = 1'b0;
                #1;
                check_eq("clr_random_pc1", {24'd0, v_a}, 32'h04);
                check_eq("clr_random_pc3", {24'd0, v_b}, 32'h04);
                @(negedge clk);
                clr = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
